// File: rtl/fetch_unit_pkg.sv
// Shared constants for the YASAC fetch stage: opcode field position, HALT opcode, FSM states.
package fetch_unit_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam logic [4:0]  HALT_OPC = 5'b11111;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// 8-bit program counter: synchronous active-low reset to RESET_PC, load has priority over increment.
module pc_counter #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       inc,
  output logic [7:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset_n)
      pc <= RESET_PC;
    else if (ld)
      pc <= ld_val;
    else if (inc)
      pc <= pc + 8'd1;
  end

endmodule

// File: rtl/fetch_unit.sv
// YASAC instruction fetch stage: PC, instruction register with valid/ready, branch flush.
// Halt detection and the HALT state exist only when FETCH_HALT_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [4:0] HALT_OPCODE = HALT_OPC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  code_addr,
  input  logic [15:0] code_data,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_take,
  input  logic [7:0]  br_target,
  output logic        halted
);

  logic [7:0] pc;
  logic       load;
  logic       pc_ld;
  logic       pc_inc;
  logic       ir_ld;
  logic       ir_clr;

  assign load      = !ir_valid || ir_ready;
  assign code_addr = pc;

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (pc_ld),
    .ld_val  (br_target),
    .inc     (pc_inc),
    .pc      (pc)
  );

`ifdef FETCH_HALT_EN
  fetch_state_t state;
  fetch_state_t state_nx;

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= ST_FETCH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    ir_clr   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (br_take) begin
          pc_ld  = 1'b1;
          ir_clr = 1'b1;
        end else if (load) begin
          pc_inc = 1'b1;
          ir_ld  = 1'b1;
          if (code_data[OPC_MSB:OPC_LSB] == HALT_OPCODE)
            state_nx = ST_HALT;
        end
      end
      ST_HALT: begin
        // Branches are ignored; only let the decoder drain the halt word.
        if (ir_valid && ir_ready)
          ir_clr = 1'b1;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  assign halted = (state == ST_HALT);
`else
  always_comb begin
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    ir_ld  = 1'b0;
    ir_clr = 1'b0;
    if (br_take) begin
      pc_ld  = 1'b1;
      ir_clr = 1'b1;
    end else if (load) begin
      pc_inc = 1'b1;
      ir_ld  = 1'b1;
    end
  end

  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (ir_ld) begin
      ir       <= code_data;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
    end else if (ir_clr) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; halt expectations follow FETCH_HALT_EN.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [7:0]  code_addr;
  logic [15:0] code_data;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_take;
  logic [7:0]  br_target;
  logic        halted;

  logic [15:0] mem [256];
  int unsigned n_checks;
  int unsigned n_fail;

  fetch_unit #(
    .RESET_PC    (8'h00),
    .HALT_OPCODE (5'b11111)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .code_addr (code_addr),
    .code_data (code_data),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_take   (br_take),
    .br_target (br_target),
    .halted    (halted)
  );

  assign code_data = mem[code_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [15:0] e_ir, input logic [7:0] e_pc,
                          input logic [7:0] e_addr);
    check({tag, ".ir"},       {16'h0, ir},         {16'h0, e_ir});
    check({tag, ".ir_pc"},    {24'h0, ir_pc},      {24'h0, e_pc});
    check({tag, ".valid"},    {31'h0, ir_valid},   32'd1);
    check({tag, ".addr"},     {24'h0, code_addr},  {24'h0, e_addr});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1101 + 16'(i);
    mem[5]    = 16'hF800;
    reset_n   = 1'b0;
    ir_ready  = 1'b1;
    br_take   = 1'b0;
    br_target = 8'h00;
    tick();
    tick();
    check("rst.valid",  {31'h0, ir_valid}, 32'd0);
    check("rst.ir",     {16'h0, ir},       32'h0);
    check("rst.ir_pc",  {24'h0, ir_pc},    32'h0);
    check("rst.addr",   {24'h0, code_addr}, 32'h0);
    check("rst.halted", {31'h0, halted},   32'd0);

    // Stream
    reset_n = 1'b1;
    tick(); check_ir("s0", 16'h1101, 8'h00, 8'h01);
    tick(); check_ir("s1", 16'h1102, 8'h01, 8'h02);

    // Stall for three cycles
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_ir("stall", 16'h1102, 8'h01, 8'h02);
    end
    ir_ready = 1'b1;
    tick(); check_ir("release", 16'h1103, 8'h02, 8'h03);

    // Branch while stalled
    ir_ready  = 1'b0;
    br_take   = 1'b1;
    br_target = 8'h40;
    tick();
    check("br.valid", {31'h0, ir_valid}, 32'd0);
    check("br.addr",  {24'h0, code_addr}, 32'h40);
    br_take = 1'b0;
    tick(); check_ir("br.fetch", 16'h1141, 8'h40, 8'h41);
    ir_ready = 1'b1;
    tick(); check_ir("br.next", 16'h1142, 8'h41, 8'h42);

    // Branch with ir consumed on the same edge, to the top address
    br_take   = 1'b1;
    br_target = 8'hFF;
    tick();
    check("wrap.valid", {31'h0, ir_valid}, 32'd0);
    check("wrap.addr",  {24'h0, code_addr}, 32'hFF);
    br_take = 1'b0;
    tick(); check_ir("wrap.ff", 16'h1200, 8'hFF, 8'h00);
    tick(); check_ir("wrap.0",  16'h1101, 8'h00, 8'h01);
    tick(); check_ir("wrap.1",  16'h1102, 8'h01, 8'h02);
    tick(); check_ir("wrap.2",  16'h1103, 8'h02, 8'h03);
    tick(); check_ir("wrap.3",  16'h1104, 8'h03, 8'h04);
    tick(); check_ir("wrap.4",  16'h1105, 8'h04, 8'h05);
    tick(); check_ir("halt.ld", 16'hF800, 8'h05, 8'h06);

`ifdef FETCH_HALT_EN
    check("halt.halted", {31'h0, halted}, 32'd1);
    ir_ready = 1'b0;
    tick(); check_ir("halt.hold", 16'hF800, 8'h05, 8'h06);
    ir_ready = 1'b1;
    tick();
    check("halt.drain.valid", {31'h0, ir_valid}, 32'd0);
    check("halt.drain.ir",    {16'h0, ir},       32'hF800);
    check("halt.drain.addr",  {24'h0, code_addr}, 32'h06);
    br_take   = 1'b1;
    br_target = 8'h40;
    tick();
    check("halt.br.addr",   {24'h0, code_addr}, 32'h06);
    check("halt.br.valid",  {31'h0, ir_valid},  32'd0);
    check("halt.br.halted", {31'h0, halted},    32'd1);
    reset_n = 1'b0;
    tick();
    check("halt.rst.halted", {31'h0, halted},    32'd0);
    check("halt.rst.valid",  {31'h0, ir_valid},  32'd0);
    check("halt.rst.addr",   {24'h0, code_addr}, 32'h00);
    br_take = 1'b0;
    reset_n = 1'b1;
    tick(); check_ir("halt.restart", 16'h1101, 8'h00, 8'h01);
`else
    check("nohalt.halted", {31'h0, halted}, 32'd0);
    tick(); check_ir("nohalt.next", 16'h1107, 8'h06, 8'h07);
    check("nohalt.halted2", {31'h0, halted}, 32'd0);
`endif

    // Reset asserted mid-stall
    ir_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("rst2.valid", {31'h0, ir_valid}, 32'd0);
    check("rst2.addr",  {24'h0, code_addr}, 32'h00);
    check("rst2.ir",    {16'h0, ir},       32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
